// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load/store type codes, FSM states,
// writeback-select codes and the store-lane helpers.
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    // funct3 access types (sb/sh/sw share codes with lb/lh/lw)
    localparam logic [2:0] DM_LB  = 3'b000;
    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LW  = 3'b010;
    localparam logic [2:0] DM_LBU = 3'b100;
    localparam logic [2:0] DM_LHU = 3'b101;

    // Writeback mux select codes
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Access size is carried in the low two bits of funct3.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b10:   is_misaligned = (offset != 2'b00);
            2'b01:   is_misaligned = offset[0];
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   store_be = 4'b0001 << offset;
            2'b01:   store_be = 4'b0011 << {offset[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store data across all lanes; the byte enables pick the lane.
    function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Word-aligned data-bus interface with a req/ack handshake.
interface mem_access_stage_if;
    import mem_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      dm_type,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension
    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (dm_type)
            DM_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            DM_LH:   result = {{16{half_sel[15]}}, half_sel};
            DM_LBU:  result = {24'd0, byte_sel};
            DM_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns loads/stores into req/ack bus transactions, stalls
// the front of the pipeline while the access is outstanding, and aligns load data.
// Optional macro MEM_TIMEOUT_EN adds a no-ack timeout that reports o_bus_err.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  i_ALU_out,
    input  logic [XLEN-1:0]  i_Store_Data,
    input  logic [4:0]       i_rd,
    input  logic [XLEN-1:0]  i_PC_plus_4,
    input  logic             i_RegWrite,
    input  logic             i_MemWrite,
    input  logic             i_MemRead,
    input  logic [1:0]       i_WDSel,
    input  logic [2:0]       i_DMType,
    mem_access_stage_if.master bus,
    output logic [XLEN-1:0]  o_mem_rdata,
    output logic [XLEN-1:0]  o_ALU_out,
    output logic [4:0]       o_rd,
    output logic [XLEN-1:0]  o_PC_plus_4,
    output logic [1:0]       o_WDSel,
    output logic             o_RegWrite,
    output logic             o_stall,
    output logic             o_misalign,
    output logic             o_bus_err
);

    // Reject configurations where the counter cannot reach the timeout
    if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
        $error("mem_access_stage: TIMEOUT_CYCLES must be below 2**CNT_W");
    end

    state_e          state_q, state_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] aligned;
    logic            mem_op;
    logic            mis_raw;
    logic            req;
    logic            capture;

    assign mem_op  = i_MemRead | i_MemWrite;
    assign mis_raw = mem_op & is_misaligned(i_DMType[1:0], i_ALU_out[1:0]);

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Timeout counter and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // State register and read-data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rdata_q <= bus.rdata;
            end
        end
    end

    // Next-state and handshake control
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        capture = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !mis_raw) begin
                    req = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d = CNT_W'(1);
`endif
                    if (bus.ack) begin
                        capture = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                        if (CNT_W'(1) >= CNT_W'(TIMEOUT_CYCLES)) begin
                            state_d = ST_DONE;
                            err_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (bus.ack) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q + CNT_W'(1) >= CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_load_align u_align (
        .word    (rdata_q),
        .offset  (i_ALU_out[1:0]),
        .dm_type (i_DMType),
        .result  (aligned)
    );

    // Bus request fields; EX/MEM is frozen while req is high so these hold steady
    assign bus.req   = req & ~reset;
    assign bus.we    = req & ~reset & i_MemWrite;
    assign bus.addr  = {i_ALU_out[XLEN-1:2], 2'b00};
    assign bus.be    = i_MemWrite ? store_be(i_DMType[1:0], i_ALU_out[1:0]) : 4'b1111;
    assign bus.wdata = store_wdata(i_DMType[1:0], i_Store_Data);

`ifdef MEM_TIMEOUT_EN
    assign o_bus_err = ~reset & err_q & (state_q == ST_DONE);
`else
    assign o_bus_err = 1'b0;
`endif

    // Pipeline-facing outputs
    assign o_stall     = req & ~reset;
    assign o_misalign  = ~reset & mis_raw & (state_q == ST_IDLE);
    assign o_mem_rdata = (~reset && state_q == ST_DONE && !o_bus_err) ? aligned : '0;
    assign o_RegWrite  = i_RegWrite & ~reset & ~o_stall & ~o_misalign & ~o_bus_err;

    assign o_ALU_out   = i_ALU_out;
    assign o_rd        = i_rd;
    assign o_PC_plus_4 = i_PC_plus_4;
    assign o_WDSel     = i_WDSel;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboard of expected completions, bus responder
// with programmable ack latency.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_ALU_out, i_Store_Data, i_PC_plus_4;
    logic [4:0]  i_rd;
    logic        i_RegWrite, i_MemWrite, i_MemRead;
    logic [1:0]  i_WDSel;
    logic [2:0]  i_DMType;
    logic [31:0] o_mem_rdata, o_ALU_out, o_PC_plus_4;
    logic [4:0]  o_rd;
    logic [1:0]  o_WDSel;
    logic        o_RegWrite, o_stall, o_misalign, o_bus_err;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_ALU_out    (i_ALU_out),
        .i_Store_Data (i_Store_Data),
        .i_rd         (i_rd),
        .i_PC_plus_4  (i_PC_plus_4),
        .i_RegWrite   (i_RegWrite),
        .i_MemWrite   (i_MemWrite),
        .i_MemRead    (i_MemRead),
        .i_WDSel      (i_WDSel),
        .i_DMType     (i_DMType),
        .bus          (bus),
        .o_mem_rdata  (o_mem_rdata),
        .o_ALU_out    (o_ALU_out),
        .o_rd         (o_rd),
        .o_PC_plus_4  (o_PC_plus_4),
        .o_WDSel      (o_WDSel),
        .o_RegWrite   (o_RegWrite),
        .o_stall      (o_stall),
        .o_misalign   (o_misalign),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        regw;
        logic [31:0] stalls;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Results of the most recent run_op
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_we, r_regw, r_req, r_err, r_ok;
    int          r_reqs;

    task automatic drive_op(input logic rd, input logic wr, input logic regw,
                            input logic [2:0] dm, input logic [31:0] addr, input logic [31:0] data);
        i_MemRead    = rd;
        i_MemWrite   = wr;
        i_RegWrite   = regw;
        i_DMType     = dm;
        i_ALU_out    = addr;
        i_Store_Data = data;
        i_rd         = 5'd5;
        i_PC_plus_4  = addr + 32'd4;
        i_WDSel      = WD_MEM;
    endtask

    // Responds to the request (ack on the ack_at-th req cycle, 0 = never) and
    // records the first request and the completion cycle.
    task automatic run_op(input int ack_at, input logic [31:0] rdata);
        r_reqs = 0; r_ok = 1'b0;
        r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
        r_rdata = '0; r_regw = 1'b0; r_req = 1'b0; r_err = 1'b0;
        for (int c = 0; c < 64; c++) begin
            bus.ack   = (ack_at != 0) && (r_reqs + 1 == ack_at);
            bus.rdata = bus.ack ? rdata : ~rdata;
            @(negedge clk);
            if (o_stall !== 1'b1) begin
                r_rdata = o_mem_rdata;
                r_regw  = o_RegWrite;
                r_req   = bus.req;
                r_err   = o_bus_err;
                r_ok    = 1'b1;
                @(posedge clk); #1;
                break;
            end
            if (bus.req === 1'b1) begin
                if (r_reqs == 0) begin
                    r_addr = bus.addr; r_wdata = bus.wdata; r_be = bus.be; r_we = bus.we;
                end
                r_reqs++;
            end
            @(posedge clk); #1;
        end
        bus.ack    = 1'b0;
        i_MemRead  = 1'b0;
        i_MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ack = 1'b0; bus.rdata = 32'h0;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h100, 32'h0);
        @(negedge clk);
        tests++;
        if ({bus.req, o_stall, o_RegWrite, o_misalign, o_bus_err} !== 5'b0)
            $display("FAIL reset_ctrl: req/stall/regw/mis/err=%b expected 00000",
                     {bus.req, o_stall, o_RegWrite, o_misalign, o_bus_err});
        tests++;
        if (o_mem_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got %h expected 00000000", o_mem_rdata);
        end
        if ({bus.req, o_stall, o_RegWrite, o_misalign, o_bus_err} !== 5'b0) fails++;
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h102, 32'h0);
        @(negedge clk);
        tests++;
        if (o_misalign !== 1'b0) begin
            fails++; $display("FAIL reset_misalign: got %b expected 0", o_misalign);
        end
        @(posedge clk); #1;
        i_MemRead = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        i_MemRead = 1'b0; i_MemWrite = 1'b0; i_RegWrite = 1'b1;
        i_ALU_out = 32'h12345678; i_rd = 5'd9; i_PC_plus_4 = 32'h400; i_WDSel = WD_PC4;
        i_DMType = DM_LW; i_Store_Data = 32'hFFFFFFFF;
        @(negedge clk);
        tests++;
        if ({o_ALU_out, o_rd, o_PC_plus_4, o_WDSel} !== {32'h12345678, 5'd9, 32'h400, WD_PC4}) begin
            fails++; $display("FAIL pass_fields: alu=%h rd=%0d pc4=%h wd=%b", o_ALU_out, o_rd, o_PC_plus_4, o_WDSel);
        end
        tests++;
        if ({o_RegWrite, o_stall, bus.req, o_misalign} !== 4'b1000) begin
            fails++; $display("FAIL pass_ctrl: regw/stall/req/mis=%b expected 1000",
                              {o_RegWrite, o_stall, bus.req, o_misalign});
        end
        tests++;
        if (o_mem_rdata !== 32'h0) begin
            fails++; $display("FAIL pass_rdata: got %h expected 00000000", o_mem_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        exp_t e;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h100, 32'h0);
        sb_q.push_back('{32'hDEADBEEF, 1'b1, 32'd4});
        run_op(4, 32'hDEADBEEF);
        e = sb_q.pop_front();
        tests++;
        if (!r_ok) begin
            fails++; $display("FAIL lw_done: no completion within cycle budget");
        end
        tests++;
        if (32'(r_reqs) !== e.stalls) begin
            fails++; $display("FAIL lw_stalls: got %0d expected %0d", r_reqs, e.stalls);
        end
        tests++;
        if ({r_rdata, r_regw, r_req} !== {e.rdata, e.regw, 1'b0}) begin
            fails++; $display("FAIL lw_result: rdata=%h regw=%b req=%b expected %h 1 0",
                              r_rdata, r_regw, r_req, e.rdata);
        end
        tests++;
        if ({r_addr, r_we, r_be} !== {32'h100, 1'b0, 4'hF}) begin
            fails++; $display("FAIL lw_bus: addr=%h we=%b be=%b", r_addr, r_we, r_be);
        end
    endtask

    task automatic test_store();
        logic        rds   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  dms   [5] = '{DM_LB, DM_LH, DM_LW, DM_LB, DM_LH};
        logic [31:0] addrs [5] = '{32'h203, 32'h102, 32'h204, 32'h201, 32'h300};
        logic [31:0] datas [5] = '{32'h000000A5, 32'h1234BEEF, 32'hCAFEF00D, 32'h0000007E, 32'hFFFF0102};
        logic [3:0]  bes   [5] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010, 4'b0011};
        logic [31:0] wds   [5] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'hCAFEF00D, 32'h7E7E7E7E, 32'h01020102};
        logic [31:0] bas   [5] = '{32'h200, 32'h100, 32'h204, 32'h200, 32'h300};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_op(rds[i], 1'b1, 1'b0, dms[i], addrs[i], datas[i]);
            sb_q.push_back('{32'h0, 1'b0, 32'(i % 2 + 1)});
            run_op(i % 2 + 1, 32'h0);
            e = sb_q.pop_front();
            tests++;
            if ({r_ok, 32'(r_reqs), r_regw} !== {1'b1, e.stalls, e.regw}) begin
                fails++; $display("FAIL st%0d_done: ok=%b stalls=%0d regw=%b expected 1 %0d 0",
                                  i, r_ok, r_reqs, r_regw, e.stalls);
            end
            tests++;
            if ({r_we, r_be, r_wdata, r_addr} !== {1'b1, bes[i], wds[i], bas[i]}) begin
                fails++; $display("FAIL st%0d_bus: we=%b be=%b wdata=%h addr=%h expected 1 %b %h %h",
                                  i, r_we, r_be, r_wdata, r_addr, bes[i], wds[i], bas[i]);
            end
        end
    endtask

    task automatic test_load_align();
        logic [2:0]  dms   [6] = '{DM_LH, DM_LHU, DM_LBU, DM_LB, DM_LB, DM_LW};
        logic [31:0] addrs [6] = '{32'h102, 32'h102, 32'h101, 32'h103, 32'h100, 32'h104};
        logic [31:0] exps  [6] = '{32'hFFFF8001, 32'h00008001, 32'h00000012, 32'hFFFFFF80,
                                   32'h00000034, 32'h80011234};
        exp_t e;
        for (int i = 0; i < 6; i++) sb_q.push_back('{exps[i], 1'b1, 32'(i % 3 + 1)});
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, 1'b0, 1'b1, dms[i], addrs[i], 32'h0);
            run_op(i % 3 + 1, 32'h80011234);
            e = sb_q.pop_front();
            tests++;
            if ({r_ok, r_rdata, r_regw, 32'(r_reqs)} !== {1'b1, e.rdata, e.regw, e.stalls}) begin
                fails++; $display("FAIL ld%0d: ok=%b rdata=%h regw=%b stalls=%0d expected %h 1 %0d",
                                  i, r_ok, r_rdata, r_regw, r_reqs, e.rdata, e.stalls);
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  dms   [3] = '{DM_LW, DM_LH, DM_LHU};
        logic [31:0] addrs [3] = '{32'h102, 32'h103, 32'h101};
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b1, 1'b0, 1'b1, dms[i], addrs[i], 32'h0);
            @(negedge clk);
            tests++;
            if ({o_misalign, bus.req, o_stall, o_RegWrite} !== 4'b1000) begin
                fails++; $display("FAIL mis%0d: mis/req/stall/regw=%b expected 1000",
                                  i, {o_misalign, bus.req, o_stall, o_RegWrite});
            end
            @(posedge clk); #1;
        end
        i_MemRead = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_stall, o_mem_rdata} !== 33'h0) begin
            fails++; $display("FAIL mis_idle: stall=%b rdata=%h expected 0 0", o_stall, o_mem_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h100, 32'h0);
        bus.ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({bus.req, o_stall} !== 2'b11) begin
            fails++; $display("FAIL rw_pending: req/stall=%b expected 11", {bus.req, o_stall});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.req, o_stall} !== 2'b00) begin
            fails++; $display("FAIL rw_drop: req/stall=%b expected 00", {bus.req, o_stall});
        end
        @(posedge clk); #1;
        i_MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.ack = 1'b1; bus.rdata = 32'h55555555;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.req, o_stall, o_mem_rdata} !== 34'h0) begin
            fails++; $display("FAIL rw_late_ack: req=%b stall=%b rdata=%h expected 0 0 0",
                              bus.req, o_stall, o_mem_rdata);
        end
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h100, 32'h0);
        sb_q.push_back('{32'h0BADF00D, 1'b1, 32'd2});
        run_op(2, 32'h0BADF00D);
        e = sb_q.pop_front();
        tests++;
        if ({r_ok, r_rdata, r_regw, 32'(r_reqs)} !== {1'b1, e.rdata, e.regw, e.stalls}) begin
            fails++; $display("FAIL rw_next: ok=%b rdata=%h regw=%b stalls=%0d expected %h 1 %0d",
                              r_ok, r_rdata, r_regw, r_reqs, e.rdata, e.stalls);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] datas [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        exp_t e;
        for (int i = 0; i < 3; i++) sb_q.push_back('{datas[i], 1'b1, 32'd1});
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h400 + 32'(4 * i), 32'h0);
            run_op(1, datas[i]);
            e = sb_q.pop_front();
            tests++;
            if ({r_ok, r_rdata, r_regw, 32'(r_reqs)} !== {1'b1, e.rdata, e.regw, e.stalls}) begin
                fails++; $display("FAIL b2b%0d: ok=%b rdata=%h regw=%b stalls=%0d expected %h 1 %0d",
                                  i, r_ok, r_rdata, r_regw, r_reqs, e.rdata, e.stalls);
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h10C, 32'h0);
        sb_q.push_back('{32'h0, 1'b0, 32'd4});
        run_op(0, 32'h0);
        e = sb_q.pop_front();
        tests++;
        if ({r_ok, 32'(r_reqs), r_err} !== {1'b1, e.stalls, 1'b1}) begin
            fails++; $display("FAIL to_stalls: ok=%b stalls=%0d err=%b expected 1 %0d 1",
                              r_ok, r_reqs, r_err, e.stalls);
        end
        tests++;
        if ({r_rdata, r_regw} !== {e.rdata, e.regw}) begin
            fails++; $display("FAIL to_result: rdata=%h regw=%b expected 0 0", r_rdata, r_regw);
        end
        @(negedge clk);
        tests++;
        if (o_bus_err !== 1'b0) begin
            fails++; $display("FAIL to_clear: err=%b expected 0", o_bus_err);
        end
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h110, 32'h0);
        sb_q.push_back('{32'h2468ACE0, 1'b1, 32'd4});
        run_op(4, 32'h2468ACE0);
        e = sb_q.pop_front();
        tests++;
        if ({r_ok, r_err, r_rdata, r_regw, 32'(r_reqs)} !== {2'b10, e.rdata, e.regw, e.stalls}) begin
            fails++; $display("FAIL to_edge_ack: ok=%b err=%b rdata=%h regw=%b stalls=%0d expected 1 0 %h 1 %0d",
                              r_ok, r_err, r_rdata, r_regw, r_reqs, e.rdata, e.stalls);
        end
    endtask
`else
    task automatic test_wait_hold();
        exp_t e;
        drive_op(1'b1, 1'b0, 1'b1, DM_LW, 32'h108, 32'h0);
        sb_q.push_back('{32'h13579BDF, 1'b1, 32'd21});
        run_op(21, 32'h13579BDF);
        e = sb_q.pop_front();
        tests++;
        if ({r_ok, r_err, r_rdata, r_regw, 32'(r_reqs)} !== {2'b10, e.rdata, e.regw, e.stalls}) begin
            fails++; $display("FAIL hold: ok=%b err=%b rdata=%h regw=%b stalls=%0d expected 1 0 %h 1 %0d",
                              r_ok, r_err, r_rdata, r_regw, r_reqs, e.rdata, e.stalls);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_load_word();
        test_store();
        test_load_align();
        test_misalign();
        test_reset_in_wait();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
